product_accumulator: RTL and testbench

- Sequential stage directly downstream of the 4-bit array multiplier.
- Consumes its 8-bit products through a valid/ready handshake and sums N_TERMS consecutive products into one wider result, i.e. a dot-product / MAC back end.
- Presents each completed sum on an output valid/ready handshake with a per-block overflow flag.
- The multiplier stays purely combinational; this block adds all registering and flow control.

---
 rtl/product_accumulator.sv | 99 +++++++++
 tb/tb_product_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: registered MAC back end for the 4-bit array multiplier.
// Sums N_TERMS consecutive 8-bit products behind a valid/ready input and
// presents each block sum, with a sticky per-block overflow flag, on a
// valid/ready output. Two states: ACCUM collects products, DONE holds the result.
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     product,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               sum,
  output logic                           overflow,
  output logic [$clog2(N_TERMS+1)-1:0]   term_count
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  // Adder is wide enough for either operand plus one carry bit, so a narrow
  // ACC_W still sees every product bit when detecting overflow.
  localparam int unsigned EXT_W = ((ACC_W > 8) ? ACC_W : 8) + 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [EXT_W-1:0] add_full;
  logic             add_carry;
  logic             last_term;

  // Unsigned add of the running sum and the incoming product.
  always_comb begin
    add_full  = EXT_W'(acc_q) + EXT_W'(product);
    add_carry = |add_full[EXT_W-1:ACC_W];
    last_term = (cnt_q == CNT_W'(N_TERMS - 1));
  end

  // Next-state logic: clear beats everything, then output transfer, then accept.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      // Aborts a partial block or drops a held result without transfer.
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_DONE) begin
      if (out_ready) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    end else if (in_valid) begin
      acc_d = add_full[ACC_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | add_carry;
      if (last_term) begin
        state_d = ST_DONE;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers; no out_ready -> in_ready path.
  always_comb begin
    in_ready   = (state_q == ST_ACCUM);
    out_valid  = (state_q == ST_DONE);
    sum        = acc_q;
    overflow   = ovf_q;
    term_count = cnt_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: three product_accumulator instances (default, ACC_W=9,
// N_TERMS=1) share one input stream; each is compared every cycle against a
// block-level model that tracks the true (unbounded) block sum.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] product;
  logic       clear;
  logic       out_ready;

  logic       in_ready0, in_ready1, in_ready2;
  logic       out_valid0, out_valid1, out_valid2;
  logic       ovf0, ovf1, ovf2;
  logic [9:0] sum0, sum2;
  logic [8:0] sum1;
  logic [2:0] tc0, tc1;
  logic [0:0] tc2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: true sum of accepted products, count, result held.
  int unsigned m_tsum [3];
  int          m_cnt  [3];
  bit          m_done [3];
  int          nt     [3] = '{4, 4, 1};
  int          aw     [3] = '{10, 9, 10};

  always #5 clk = ~clk;

  product_accumulator #(.N_TERMS(4), .ACC_W(10)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .product(product),
    .clear(clear), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
    .overflow(ovf0), .term_count(tc0)
  );

  product_accumulator #(.N_TERMS(4), .ACC_W(9)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .product(product),
    .clear(clear), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .overflow(ovf1), .term_count(tc1)
  );

  product_accumulator #(.N_TERMS(1), .ACC_W(10)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .product(product),
    .clear(clear), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
    .overflow(ovf2), .term_count(tc2)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned dut_val(input int i, input int which);
    case (which)
      0: return (i == 0) ? in_ready0  : (i == 1) ? in_ready1  : in_ready2;
      1: return (i == 0) ? out_valid0 : (i == 1) ? out_valid1 : out_valid2;
      2: return (i == 0) ? sum0       : (i == 1) ? 32'(sum1)  : sum2;
      3: return (i == 0) ? ovf0       : (i == 1) ? ovf1       : ovf2;
      default: return (i == 0) ? tc0  : (i == 1) ? tc1        : 32'(tc2);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int unsigned lim = 32'd1 << aw[i];
      chk($sformatf("u%0d in_ready", i),   dut_val(i, 0), m_done[i] ? 0 : 1);
      chk($sformatf("u%0d out_valid", i),  dut_val(i, 1), m_done[i] ? 1 : 0);
      chk($sformatf("u%0d sum", i),        dut_val(i, 2), m_tsum[i] % lim);
      chk($sformatf("u%0d overflow", i),   dut_val(i, 3), (m_tsum[i] >= lim) ? 1 : 0);
      chk($sformatf("u%0d term_count", i), dut_val(i, 4), m_cnt[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tsum[i] = 0;
      m_cnt[i]  = 0;
      m_done[i] = 0;
    end
  endtask

  task automatic model_step(input bit iv, input int unsigned p, input bit clr, input bit ordy);
    for (int i = 0; i < 3; i++) begin
      if (clr || (m_done[i] && ordy)) begin
        m_tsum[i] = 0;
        m_cnt[i]  = 0;
        m_done[i] = 0;
      end else if (!m_done[i] && iv) begin
        m_tsum[i] += p;
        m_cnt[i]++;
        if (m_cnt[i] == nt[i]) m_done[i] = 1;
      end
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance past the edge.
  task automatic cycle(input bit iv, input int unsigned p, input bit clr, input bit ordy);
    in_valid  = iv;
    product   = 8'(p);
    clear     = clr;
    out_ready = ordy;
    #1;
    check_all();
    @(posedge clk);
    #1;
    model_step(iv, p, clr, ordy);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst out_valid0", out_valid0, 0);
    chk("rst in_ready0", in_ready0, 1);
    chk("rst term_count0", tc0, 0);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int p4 [4];
    rst = 1'b1; in_valid = 1'b0; product = '0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    #9;
    rst = 1'b0;

    // Scenario 1: basic block.
    p4 = '{120, 13, 150, 15};
    foreach (p4[k]) cycle(1, p4[k], 0, 1);
    chk("s1 out_valid", out_valid0, 1);
    chk("s1 sum", sum0, 298);
    chk("s1 overflow", ovf0, 0);
    chk("s1 term_count", tc0, 4);
    cycle(0, 0, 0, 1);
    chk("s1 next out_valid", out_valid0, 0);
    chk("s1 next in_ready", in_ready0, 1);
    chk("s1 next term_count", tc0, 0);

    // Scenario 2: backpressure holds the result; product 77 not accepted.
    foreach (p4[k]) cycle(1, p4[k], 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 77, 0, 0);
      chk("s2 hold sum", sum0, 298);
      chk("s2 hold out_valid", out_valid0, 1);
      chk("s2 hold in_ready", in_ready0, 0);
    end
    cycle(0, 0, 0, 1);
    chk("s2 restart in_ready", in_ready0, 1);
    chk("s2 restart sum", sum0, 0);

    // Scenario 3: gapped 225s, then 1s on the narrow accumulator.
    for (int k = 0; k < 4; k++) begin
      cycle(1, 225, 0, 1);
      if (k < 3) cycle(0, 225, 0, 1);
    end
    chk("s3 sum w10", sum0, 900);
    chk("s3 ovf w10", ovf0, 0);
    chk("s3 sum w9", sum1, 388);
    chk("s3 ovf w9", ovf1, 1);
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 1);
    chk("s3 ones sum w9", sum1, 4);
    chk("s3 ones ovf w9", ovf1, 0);
    cycle(0, 0, 0, 1);

    // Scenario 4: clear mid-block and clear in DONE.
    cycle(1, 50, 0, 1);
    cycle(1, 60, 0, 1);
    cycle(1, 70, 1, 1);
    chk("s4 clr term_count", tc0, 0);
    chk("s4 clr sum", sum0, 0);
    p4 = '{10, 20, 30, 40};
    foreach (p4[k]) cycle(1, p4[k], 0, 0);
    chk("s4 sum", sum0, 100);
    chk("s4 out_valid", out_valid0, 1);
    cycle(0, 0, 1, 0);
    chk("s4 drop out_valid", out_valid0, 0);
    chk("s4 drop in_ready", in_ready0, 1);

    // Scenario 5: async reset between edges mid-block.
    for (int k = 0; k < 3; k++) cycle(1, 9, 0, 1);
    async_reset();
    p4 = '{1, 2, 3, 4};
    foreach (p4[k]) cycle(1, p4[k], 0, 1);
    chk("s5 sum", sum0, 10);
    cycle(0, 0, 0, 1);

    // Scenario 6: N_TERMS=1 instance, upstream holds data while in_ready=0.
    async_reset();
    cycle(1, 10, 0, 1);
    chk("s6 sum10", sum2, 10);
    chk("s6 out_valid", out_valid2, 1);
    chk("s6 in_ready low", in_ready2, 0);
    cycle(1, 22, 0, 1);
    chk("s6 in_ready high", in_ready2, 1);
    cycle(1, 22, 0, 1);
    chk("s6 sum22", sum2, 22);
    cycle(1, 33, 0, 1);
    cycle(1, 33, 0, 1);
    chk("s6 sum33", sum2, 33);
    cycle(0, 0, 0, 1);

    // Randomized traffic with occasional clear and async reset.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(99) == 0) async_reset();
      cycle(1'($urandom_range(1)), $urandom_range(255), ($urandom_range(19) == 0),
            ($urandom_range(3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
